// File: rtl/spi_mem_emu.sv
// rtl/spi_mem_emu.sv - SPI mode-0 PSRAM/flash memory emulator oversampling the SPI bus on the system clock
module spi_mem_emu #(
    parameter int    DEPTH      = 1024,
    parameter int    ADDR_BYTES = 3,
    parameter int    MODE       = 0,
    parameter string INIT_FILE  = ""
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic sclk_in,
    input  logic cs_in,
    input  logic mosi_in,
    output logic miso_out,
    output logic miso_oe_out,
    output logic wel_out,
    output logic cmd_err_out
);
    localparam int AW    = $clog2(DEPTH);
    localparam int ABITS = 8 * ADDR_BYTES;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_READ,
        S_STATUS,
        S_WRITE,
        S_NOP,
        S_IGNORE
    } state_t;

    logic [7:0] mem [DEPTH];

    logic [1:0] sclk_sync, cs_sync, mosi_sync;
    logic       sclk_d, cs_d;
    logic       sclk_s, cs_s, mosi_s;
    logic       rise_ev, fall_ev, cs_fall;

    state_t        state_q, state_d;
    logic [5:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    sh_q, sh_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          wel_q, wel_d;
    logic          oe_q, oe_d;
    logic          err_q, err_d;
    logic          extra_q, extra_d;

    logic          wr_en;
    logic [7:0]    wr_data;
    logic [AW-1:0] rd_addr;
    logic [7:0]    load_byte;

    // Two-flop synchronisers plus one extra stage on sclk/cs for edge detection; CS idles high
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sclk_sync <= 2'b00;
            cs_sync   <= 2'b11;
            mosi_sync <= 2'b00;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[0], sclk_in};
            cs_sync   <= {cs_sync[0], cs_in};
            mosi_sync <= {mosi_sync[0], mosi_in};
            sclk_d    <= sclk_sync[1];
            cs_d      <= cs_sync[1];
        end
    end

    assign sclk_s  = sclk_sync[1];
    assign cs_s    = cs_sync[1];
    assign mosi_s  = mosi_sync[1];
    assign rise_ev = ~cs_s & sclk_s & ~sclk_d;
    assign fall_ev = ~cs_s & ~sclk_s & sclk_d;
    assign cs_fall = ~cs_s & cs_d;

    // Byte to load into the output shifter: next address once a full byte has gone out
    always_comb begin
        rd_addr   = (oe_q && bit_cnt_q == 6'd7) ? addr_q + AW'(1) : addr_q;
        load_byte = (state_q == S_STATUS) ? {6'b0, wel_q, 1'b0} : mem[rd_addr];
    end

    // Next-state and datapath decisions for one system clock
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sh_d      = sh_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        wel_d     = wel_q;
        oe_d      = oe_q;
        err_d     = 1'b0;
        extra_d   = extra_q;
        wr_en     = 1'b0;
        wr_data   = {sh_q[6:0], mosi_s};

        if (cs_s) begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
            oe_d      = 1'b0;
            extra_d   = 1'b0;
            // WREN/WRDI only take effect when the frame was exactly one byte long
            if (state_q == S_NOP && !extra_q) begin
                if (cmd_q == 8'h06)
                    wel_d = 1'b1;
                else if (cmd_q == 8'h04)
                    wel_d = 1'b0;
            end
            // Flash drops the latch when a program transaction ends
            if (MODE == 1 && cmd_q == 8'h02 && (state_q == S_ADDR || state_q == S_WRITE))
                wel_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cs_fall) begin
                        state_d   = S_CMD;
                        bit_cnt_d = '0;
                    end
                end
                S_CMD: begin
                    if (rise_ev) begin
                        sh_d      = {sh_q[6:0], mosi_s};
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        if (bit_cnt_q == 6'd7) begin
                            cmd_d     = sh_d;
                            bit_cnt_d = '0;
                            addr_d    = '0;
                            case (sh_d)
                                8'h03, 8'h0B, 8'h02: state_d = S_ADDR;
                                8'h05:               state_d = S_STATUS;
                                8'h06, 8'h04:        state_d = S_NOP;
                                default: begin
                                    state_d = S_IGNORE;
                                    err_d   = 1'b1;
                                end
                            endcase
                        end
                    end
                end
                S_ADDR: begin
                    if (rise_ev) begin
                        addr_d    = {addr_q[AW-2:0], mosi_s};
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        if (bit_cnt_q == 6'(ABITS - 1)) begin
                            bit_cnt_d = '0;
                            case (cmd_q)
                                8'h03:   state_d = S_READ;
                                8'h0B:   state_d = S_DUMMY;
                                default: state_d = S_WRITE;
                            endcase
                        end
                    end
                end
                S_DUMMY: begin
                    if (rise_ev) begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        if (bit_cnt_q == 6'd7) begin
                            bit_cnt_d = '0;
                            state_d   = S_READ;
                        end
                    end
                end
                S_READ, S_STATUS: begin
                    if (fall_ev) begin
                        if (!oe_q || bit_cnt_q == 6'd7) begin
                            sh_d      = load_byte;
                            oe_d      = 1'b1;
                            bit_cnt_d = '0;
                            if (oe_q && state_q == S_READ)
                                addr_d = addr_q + AW'(1);
                        end else begin
                            sh_d      = {sh_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 6'd1;
                        end
                    end
                end
                S_WRITE: begin
                    if (rise_ev) begin
                        sh_d      = {sh_q[6:0], mosi_s};
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        if (bit_cnt_q == 6'd7) begin
                            wr_en     = (MODE == 0) || wel_q;
                            bit_cnt_d = '0;
                            addr_d    = addr_q + AW'(1);
                        end
                    end
                end
                S_NOP: begin
                    if (rise_ev)
                        extra_d = 1'b1;
                end
                S_IGNORE: begin
                    state_d = S_IGNORE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            sh_q      <= '0;
            cmd_q     <= '0;
            addr_q    <= '0;
            wel_q     <= 1'b0;
            oe_q      <= 1'b0;
            err_q     <= 1'b0;
            extra_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sh_q      <= sh_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            wel_q     <= wel_d;
            oe_q      <= oe_d;
            err_q     <= err_d;
            extra_q   <= extra_d;
        end
    end

    // Memory commit; flash programming can only clear bits
    always_ff @(posedge clk_in) begin
        if (wr_en)
            mem[addr_q] <= (MODE == 1) ? (mem[addr_q] & wr_data) : wr_data;
    end

    assign miso_out    = oe_q & sh_q[7];
    assign miso_oe_out = oe_q;
    assign wel_out     = wel_q;
    assign cmd_err_out = err_q;

endmodule

// File: tb/tb_spi_mem_emu.sv
// tb/tb_spi_mem_emu.sv - randomized bench for spi_mem_emu against a byte-array reference model
`timescale 1ns/1ps
module tb_spi_mem_emu;
    localparam int DEPTH = 1024;
    localparam int HALF  = 40;

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b0;
    logic sclk_in  = 1'b0;
    logic cs_p     = 1'b1;
    logic cs_f     = 1'b1;
    logic mosi_in  = 1'b0;
    logic miso_p, oe_p, wel_p, err_p;
    logic miso_f, oe_f, wel_f, err_f;

    always #5 clk_in = ~clk_in;

    spi_mem_emu #(.DEPTH(DEPTH), .ADDR_BYTES(3), .MODE(0), .INIT_FILE("")) u_psram (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .sclk_in(sclk_in), .cs_in(cs_p), .mosi_in(mosi_in),
        .miso_out(miso_p), .miso_oe_out(oe_p), .wel_out(wel_p), .cmd_err_out(err_p)
    );

    spi_mem_emu #(.DEPTH(DEPTH), .ADDR_BYTES(3), .MODE(1), .INIT_FILE("")) u_flash (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .sclk_in(sclk_in), .cs_in(cs_f), .mosi_in(mosi_in),
        .miso_out(miso_f), .miso_oe_out(oe_f), .wel_out(wel_f), .cmd_err_out(err_f)
    );

    logic [7:0] ref_p [DEPTH];
    logic [7:0] ref_f [DEPTH];
    bit         wel_ref [2];
    logic [7:0] wbuf [$];
    int n_tests = 0;
    int n_fail  = 0;
    int err_cnt_p = 0, miso_hi_p = 0, oe_hi_p = 0;

    // Activity counters for the psram instance, sampled away from the active edge
    always @(negedge clk_in) begin
        if (err_p)  err_cnt_p++;
        if (miso_p) miso_hi_p++;
        if (oe_p)   oe_hi_p++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cs_set(input int sel, input logic v);
        if (sel == 0) cs_p = v;
        else          cs_f = v;
    endtask

    task automatic spi_start(input int sel);
        @(negedge clk_in);
        cs_set(sel, 1'b0);
        #(HALF);
    endtask

    task automatic spi_stop(input int sel);
        #(HALF);
        cs_set(sel, 1'b1);
        repeat (8) @(negedge clk_in);
    endtask

    // Mode-0 master: shift out the top n bits of tx, sample MISO just before each rising edge
    task automatic spi_bits(input int sel, input logic [7:0] tx, input int n,
                            output logic [7:0] rx, output bit oe_ok);
        rx    = '0;
        oe_ok = 1'b1;
        for (int i = 7; i > 7 - n; i--) begin
            mosi_in = tx[i];
            #(HALF);
            rx = {rx[6:0], (sel == 0) ? miso_p : miso_f};
            if (((sel == 0) ? oe_p : oe_f) !== 1'b1) oe_ok = 1'b0;
            sclk_in = 1'b1;
            #(HALF);
            sclk_in = 1'b0;
        end
    endtask

    task automatic send_hdr(input int sel, input logic [7:0] cmd, input logic [23:0] a);
        logic [7:0] rx;
        bit ok;
        spi_bits(sel, cmd, 8, rx, ok);
        for (int b = 2; b >= 0; b--) spi_bits(sel, a[b*8 +: 8], 8, rx, ok);
    endtask

    // Program wbuf starting at a; the model applies each instance's write rule byte by byte
    task automatic op_write(input int sel, input logic [23:0] a);
        logic [7:0] rx;
        bit ok;
        int idx;
        idx = int'(a) % DEPTH;
        spi_start(sel);
        send_hdr(sel, 8'h02, a);
        foreach (wbuf[k]) begin
            spi_bits(sel, wbuf[k], 8, rx, ok);
            if (sel == 0) ref_p[idx] = wbuf[k];
            else if (wel_ref[1]) ref_f[idx] = ref_f[idx] & wbuf[k];
            idx = (idx + 1) % DEPTH;
        end
        spi_stop(sel);
        if (sel == 1) wel_ref[1] = 1'b0;
        chk("wel_after_write", (sel == 0) ? wel_p : wel_f, wel_ref[sel]);
    endtask

    task automatic op_read(input int sel, input logic [23:0] a, input int n, input bit fast);
        logic [7:0] rx;
        bit ok;
        int idx;
        idx = int'(a) % DEPTH;
        spi_start(sel);
        send_hdr(sel, fast ? 8'h0B : 8'h03, a);
        if (fast) spi_bits(sel, 8'h00, 8, rx, ok);
        for (int k = 0; k < n; k++) begin
            spi_bits(sel, 8'hFF, 8, rx, ok);
            chk(fast ? "fast_read_data" : "read_data", rx, (sel == 0) ? ref_p[idx] : ref_f[idx]);
            chk("read_oe", ok, 1);
            idx = (idx + 1) % DEPTH;
        end
        spi_stop(sel);
        chk("oe_after_cs", (sel == 0) ? oe_p : oe_f, 0);
    endtask

    task automatic op_cmd(input int sel, input logic [7:0] c, input int extra);
        logic [7:0] rx;
        bit ok;
        spi_start(sel);
        spi_bits(sel, c, 8, rx, ok);
        if (extra > 0) spi_bits(sel, 8'h5A, extra, rx, ok);
        spi_stop(sel);
        if (extra == 0 && c == 8'h06) wel_ref[sel] = 1'b1;
        if (extra == 0 && c == 8'h04) wel_ref[sel] = 1'b0;
        chk("wel_after_cmd", (sel == 0) ? wel_p : wel_f, wel_ref[sel]);
    endtask

    task automatic op_status(input int sel);
        logic [7:0] rx;
        bit ok;
        spi_start(sel);
        spi_bits(sel, 8'h05, 8, rx, ok);
        for (int k = 0; k < 2; k++) begin
            spi_bits(sel, 8'h00, 8, rx, ok);
            chk("status", rx, {6'b0, wel_ref[sel], 1'b0});
        end
        spi_stop(sel);
    endtask

    initial begin
        logic [7:0] rx;
        bit ok;
        int e0, m0, o0;
        logic [23:0] a;
        int n;

        // Power-up image for both devices, mirrored in the model
        for (int i = 0; i < DEPTH; i++) begin
            ref_p[i] = 8'($urandom);
            ref_f[i] = 8'($urandom);
        end
        ref_p[16'h10] = 8'hA5;
        ref_p[16'h11] = 8'h3C;
        ref_f[16'h20] = 8'hF3;
        for (int i = 0; i < DEPTH; i++) begin
            u_psram.mem[i] = ref_p[i];
            u_flash.mem[i] = ref_f[i];
        end
        wel_ref[0] = 1'b0;
        wel_ref[1] = 1'b0;

        repeat (4) @(negedge clk_in);
        chk("reset_outputs", {miso_p, oe_p, wel_p, err_p, miso_f, oe_f, wel_f, err_f}, 0);
        rst_n_in = 1'b1;
        repeat (4) @(negedge clk_in);

        // Image reads: normal and fast
        op_read(0, 24'h000010, 2, 1'b0);
        op_read(0, 24'h000010, 1, 1'b1);

        // Burst write across the top of memory, then read back over the wrap
        wbuf = '{8'h11, 8'h22, 8'h33};
        op_write(0, 24'h0003FF);
        op_read(0, 24'h0003FF, 3, 1'b0);
        op_read(0, 24'h000000, 1, 1'b0);
        chk("wrap_model", ref_p[0], 8'h22);

        // Flash: locked write dropped, WREN then AND-program, latch cleared afterwards
        wbuf = '{8'h00};
        op_write(1, 24'h000020);
        op_read(1, 24'h000020, 1, 1'b0);
        op_cmd(1, 8'h06, 0);
        wbuf = '{8'h0F};
        op_write(1, 24'h000020);
        op_read(1, 24'h000020, 1, 1'b0);
        chk("flash_and_model", ref_f[16'h20], 8'h03);
        op_status(1);

        // Unsupported command: one error pulse, bus stays quiet
        e0 = err_cnt_p; m0 = miso_hi_p; o0 = oe_hi_p;
        spi_start(0);
        spi_bits(0, 8'h9F, 8, rx, ok);
        spi_bits(0, 8'hFF, 8, rx, ok);
        spi_bits(0, 8'hFF, 8, rx, ok);
        spi_stop(0);
        chk("cmd_err_pulses", err_cnt_p - e0, 1);
        chk("ignore_miso", miso_hi_p - m0, 0);
        chk("ignore_oe", oe_hi_p - o0, 0);

        // WREN/WRDI with trailing bits are ignored
        op_cmd(1, 8'h06, 1);
        op_cmd(0, 8'h06, 0);
        op_cmd(0, 8'h04, 3);
        op_status(0);

        // Reset mid-write: first byte committed, partial second byte lost, WEL cleared
        a = 24'h0A0155;
        spi_start(0);
        send_hdr(0, 8'h02, a);
        spi_bits(0, 8'h96, 8, rx, ok);
        ref_p[16'h155] = 8'h96;
        spi_bits(0, 8'h00, 4, rx, ok);
        @(negedge clk_in);
        rst_n_in = 1'b0;
        @(negedge clk_in);
        chk("midreset_outputs", {miso_p, oe_p, wel_p, err_p, miso_f, oe_f, wel_f, err_f}, 0);
        wel_ref[0] = 1'b0;
        wel_ref[1] = 1'b0;
        cs_p = 1'b1;
        sclk_in = 1'b0;
        repeat (4) @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (4) @(negedge clk_in);
        op_read(0, a, 2, 1'b0);

        // Random psram bursts with garbage upper address bits
        for (int it = 0; it < 20; it++) begin
            a = 24'($urandom);
            if (it % 4 == 0) a[9:0] = 10'h3FE;
            n = $urandom_range(1, 6);
            wbuf.delete();
            for (int k = 0; k < n; k++) wbuf.push_back(8'($urandom));
            op_write(0, a);
            op_read(0, a, n + 1, 1'($urandom));
        end

        // Random flash operation mix
        for (int it = 0; it < 20; it++) begin
            a = 24'($urandom);
            case ($urandom_range(0, 3))
                0: op_cmd(1, ($urandom_range(0, 2) != 0) ? 8'h06 : 8'h04, ($urandom_range(0, 3) == 0) ? 2 : 0);
                1: begin
                    wbuf.delete();
                    n = $urandom_range(1, 4);
                    for (int k = 0; k < n; k++) wbuf.push_back(8'($urandom));
                    op_write(1, a);
                    op_read(1, a, n, 1'b0);
                end
                2: op_read(1, a, $urandom_range(1, 4), 1'($urandom));
                default: op_status(1);
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
